alu_stream_unit: RTL
====================

// Module: alu_stream_unit
// PURPOSE
//  Parametrised successor to the fixed 4-bit ALU: a streaming ALU with valid/ready handshake on both sides.
//  Multi-cycle mul/div latency is configurable, div-by-zero is flagged, and results drain through an
//  internal output FIFO.
//  Sits between the input command FIFO and the result consumer in the ALU datapath; replaces the ALU+output FIFO pair.
// PARAMETERS
//  DATA_W     4  operand width (bits); result width RES_W = 2*DATA_W+1
//  MC_CYCLES  3  cycles from accept to FIFO write for MUL/DIV (>=2)
//  OUT_DEPTH  8  output FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  reset      in   1        synchronous, active-low (reset==0 resets on posedge clk)
//  in_valid   in   1        command valid
//  in_ready   out  1        unit accepts command this cycle
//  in_a       in   DATA_W   operand A (unsigned)
//  in_b       in   DATA_W   operand B (unsigned)
//  in_op      in   2        0 ADD, 1 SUB, 2 MUL, 3 DIV
//  out_valid  out  1        FIFO head valid
//  out_ready  in   1        consumer takes head
//  out_result out  RES_W    result at FIFO head
//  out_err    out  1        head was DIV by zero
//  busy       out  1        MUL/DIV in flight or result stage occupied
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, cnt=0, stage empty, FIFO ptrs/count=0; outputs in_ready=0
//   during reset, out_valid=0, out_result=0, out_err=0, busy=0. Mid-operation reset drops any MUL/DIV in flight and all FIFO contents.
//  Accept = in_valid && in_ready at posedge; operands/op latched on accept, inputs ignored otherwise.
//  in_ready = reset && state==IDLE && !stage_v && (fifo_count < OUT_DEPTH); no pop credit (pop same cycle ignored).
//  FSM: IDLE --accept ADD/SUB--> IDLE (stage_v<=1, result computed)
//       IDLE --accept MUL/DIV--> MULTI, cnt<=1
//       MULTI: cnt<MC_CYCLES-1 -> cnt++ ; cnt==MC_CYCLES-1 -> stage_v<=1, cnt<=0, -> IDLE
//  Stage register writes FIFO on next edge (stage_v && FIFO not full, always true by in_ready rule); stage_v<=0.
//  Latency accept->out_valid (empty FIFO): ADD/SUB 2 cycles; MUL/DIV MC_CYCLES+1 cycles. Throughput ADD/SUB 1 per 2 cycles.
//  Arithmetic (zero-extend to RES_W):
//   ADD a+b; SUB (a-b) mod 2^RES_W (two's complement wrap); MUL a*b; DIV floor(a/b), err=0.
//   DIV with b==0: result = all ones (RES_W'h1FF for DATA_W=4), err=1.
//  FIFO: show-ahead; pop when out_valid && out_ready; push+pop same cycle -> count unchanged, both pointers advance.
//   Pointers wrap at OUT_DEPTH-1 -> 0. Push when full impossible by construction (assert).
//   out_result/out_err held stable while out_valid && !out_ready.
//  busy = (state==MULTI) || stage_v.
//  Results leave in acceptance order; no reordering.
// STRUCTURE
//  alu_stream_pkg: op enum (OP_ADD..OP_DIV), state enum (ST_IDLE, ST_MULTI), RES_W function of DATA_W.
//  Sub-module alu_result_fifo (width RES_W+1 {err,result}, depth OUT_DEPTH, full/empty/count outputs).
//  Top holds FSM, cycle counter, operand latches and result stage register.
// TESTING  (DATA_W=4, MC_CYCLES=3, OUT_DEPTH=8)
//  1 ADD a=9 b=8, out_ready=1 -> out_valid 2 cycles after accept, out_result=17, err=0; SUB a=3 b=5 -> 9'h1FE.
//  2 MUL a=15 b=15 -> in_ready=0 for 3 cycles, busy=1; out_result=225 at accept+4; DIV a=13 b=4 -> 3.
//  3 DIV a=7 b=0 -> out_result=9'h1FF, out_err=1; next ADD 1+1 -> out_result=2, out_err=0.
//  4 out_ready=0, issue 8 ADDs (k+k, k=0..7) -> in_ready drops after 8th push, FIFO full; release -> results 0,2,..,14 in order.
//  5 FIFO full, out_ready=1 one cycle -> one pop, in_ready rises next cycle; pointer wrap verified over 20 transactions.
//  6 Accept MUL, assert reset=0 at cnt==1 -> out_valid=0, busy=0, no result ever emitted; in_ready=1 cycle after reset=1.

Source files
------------

// File: rtl/alu_stream_pkg.sv
// alu_stream_pkg
// Shared types for the streaming ALU: operation encoding, control FSM
// states, and the result-width rule (2*DATA_W+1, wide enough for a full
// product plus headroom for the all-ones divide-by-zero marker).
package alu_stream_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

  function automatic int res_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Show-ahead synchronous FIFO holding {err, result} words.
// Ports: clk, reset (sync active-low), push/push_data, pop, head_data
// (zero while empty), full, empty, count (0..DEPTH).
module alu_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  // Push is gated by full as a belt-and-braces guard; pop of an empty FIFO is ignored.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  // Drive zero while empty so the head never shows stale or pre-reset data.
  assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  // Storage array: written on push, no reset needed since head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_fifo_chk.sv
// alu_result_fifo_chk
// Property checker for the output FIFO: the upstream stage must never push
// while the FIFO is full (the issue-side ready rule makes this impossible).
// Ports: clk, reset (sync active-low), push, full.
module alu_result_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: rtl/alu_stream_unit.sv
// alu_stream_unit
// Streaming ALU with valid/ready on both sides. ADD/SUB resolve in one
// cycle into a result stage register; MUL/DIV occupy the unit for
// MC_CYCLES cycles. The stage register drains into a show-ahead FIFO.
// Ports: clk, reset (sync active-low); in_valid/in_ready/in_a/in_b/in_op
// command side; out_valid/out_ready/out_result/out_err result side; busy.
module alu_stream_unit
  import alu_stream_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MC_CYCLES = 3,
  parameter int OUT_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_a,
  input  logic [DATA_W-1:0]         in_b,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [res_w(DATA_W)-1:0]  out_result,
  output logic                      out_err,
  output logic                      busy
);

  localparam int RES_W = res_w(DATA_W);
  localparam int CNT_W = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;
  localparam int FCW   = $clog2(OUT_DEPTH) + 1;

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]  a_r;
  logic [DATA_W-1:0]  b_r;
  op_e                op_r;
  logic               stage_v_r;
  logic [RES_W-1:0]   stage_res_r;
  logic               stage_err_r;

  logic               accept_s;
  logic [DATA_W-1:0]  op_a_s;
  logic [DATA_W-1:0]  op_b_s;
  op_e                op_s;
  logic [RES_W-1:0]   ea_s;
  logic [RES_W-1:0]   eb_s;
  logic [RES_W-1:0]   res_s;
  logic               err_s;

  logic [RES_W:0]     fifo_head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [FCW-1:0]     fifo_count_s;

  // No pop credit: a slot freed by a same-cycle pop is only usable next cycle.
  assign in_ready  = reset && (state_r == ST_IDLE) && !stage_v_r && (fifo_count_s < FCW'(OUT_DEPTH));
  assign accept_s  = in_valid && in_ready;
  assign busy      = (state_r == ST_MULTI) || stage_v_r;
  assign out_valid = !fifo_empty_s;
  assign out_err   = fifo_head_s[RES_W];
  assign out_result = fifo_head_s[RES_W-1:0];

  // Result datapath: live inputs for single-cycle ops, latched operands while multi-cycle.
  always_comb begin
    op_a_s = {DATA_W{1'b0}};
    op_b_s = {DATA_W{1'b0}};
    op_s   = OP_ADD;
    res_s  = {RES_W{1'b0}};
    err_s  = 1'b0;
    if (state_r == ST_MULTI) begin
      op_a_s = a_r;
      op_b_s = b_r;
      op_s   = op_r;
    end else begin
      op_a_s = in_a;
      op_b_s = in_b;
      op_s   = op_e'(in_op);
    end
    ea_s = {{(RES_W-DATA_W){1'b0}}, op_a_s};
    eb_s = {{(RES_W-DATA_W){1'b0}}, op_b_s};
    case (op_s)
      OP_ADD: res_s = ea_s + eb_s;
      OP_SUB: res_s = ea_s - eb_s;
      OP_MUL: res_s = ea_s * eb_s;
      OP_DIV: begin
        if (op_b_s == {DATA_W{1'b0}}) begin
          res_s = {RES_W{1'b1}};
          err_s = 1'b1;
        end else begin
          res_s = ea_s / eb_s;
          err_s = 1'b0;
        end
      end
      default: begin
        res_s = {RES_W{1'b0}};
        err_s = 1'b0;
      end
    endcase
  end

  // Control FSM, operand latches and result stage; the stage empties into the FIFO each cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      op_r        <= OP_ADD;
      stage_v_r   <= 1'b0;
      stage_res_r <= {RES_W{1'b0}};
      stage_err_r <= 1'b0;
    end else begin
      stage_v_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r  <= in_a;
            b_r  <= in_b;
            op_r <= op_e'(in_op);
            if ((op_e'(in_op) == OP_ADD) || (op_e'(in_op) == OP_SUB)) begin
              stage_v_r   <= 1'b1;
              stage_res_r <= res_s;
              stage_err_r <= err_s;
            end else begin
              state_r <= ST_MULTI;
              cnt_r   <= CNT_W'(1);
            end
          end
        end
        ST_MULTI: begin
          if (cnt_r == CNT_W'(MC_CYCLES - 1)) begin
            stage_v_r   <= 1'b1;
            stage_res_r <= res_s;
            stage_err_r <= err_s;
            cnt_r       <= {CNT_W{1'b0}};
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  alu_result_fifo #(
    .WIDTH (RES_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stage_v_r),
    .push_data ({stage_err_r, stage_res_r}),
    .pop       (out_valid && out_ready),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  alu_result_fifo_chk u_fifo_chk (
    .clk   (clk),
    .reset (reset),
    .push  (stage_v_r),
    .full  (fifo_full_s)
  );

endmodule
